// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- execute-stage ALU sitting behind the ALU control decoder.
//
// AND/OR/ADD/SUB (and undefined codes) retire one cycle after start is
// sampled. MUL runs as an iterative shift-add over up to WIDTH cycles, with
// busy high while it runs so pipeline control can stall; start is ignored
// while busy.
//
// Optional build macro:
//   MUL_EARLY_EXIT_EN  - MUL also finishes as soon as the remaining multiplier
//                        bits are all zero (same result, shorter latency).
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   start     in   execute request, sampled only when busy=0
//   alu_ctrl  in   4'b0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 MUL
//   a, b      in   operands (WIDTH bits)
//   result    out  registered result of last completed op
//   zero      out  registered, result == 0
//   ovf       out  registered signed overflow of last ADD/SUB, else 0
//   busy      out  MUL in progress
//   done      out  one-cycle pulse when result/zero/ovf update
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;

  typedef enum logic {IDLE, MULT} state_e;

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]    count_q,  count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic             ovf_q,    ovf_d;
  logic             done_q,   done_d;

  // Single-cycle datapath
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic             sa, sb;

  assign sum  = a + b;
  assign diff = a - b;
  assign sa   = a[WIDTH-1];
  assign sb   = b[WIDTH-1];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (sa == sb) && (sum[WIDTH-1] != sa);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (sa != sb) && (diff[WIDTH-1] != sa);
      end
      default: begin
        // undefined codes (and MUL, handled separately) produce 0
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  // Shift-add step: this cycle's accumulator after the conditional add
  logic [WIDTH-1:0] acc_add;
  logic             mul_last;

  assign acc_add = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

`ifdef MUL_EARLY_EXIT_EN
  // Once no set bits remain above bit 0, later iterations would add nothing.
  assign mul_last = (count_q == CW'(1)) || ((mplier_q >> 1) == '0);
`else
  assign mul_last = (count_q == CW'(1));
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (alu_ctrl == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            count_d  = CW'(WIDTH);
            state_d  = MULT;
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
            done_d   = 1'b1;
          end
        end
      end
      MULT: begin
        acc_d    = acc_add;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (mul_last) begin
          result_d = acc_add;
          zero_d   = (acc_add == '0);
          ovf_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == MULT);
  assign done   = done_q;

endmodule
